// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus bridge and its address decoder.
package mmio_pkg;

  // Bus transaction phases as seen by the bridge sequencer
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mmio_state_t;

  // Value returned to the core when a peripheral never answers
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  // Byte address of slot 0 unless the instantiation overrides it
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF0000;

  // Width of a slot index; never narrower than one bit so a single slot still has a port
  function automatic int unsigned slot_width(input int unsigned nslaves);
    return (nslaves <= 32'd1) ? 32'd1 : $clog2(nslaves);
  endfunction

endpackage

// File: rtl/mmio_slot_decode.sv
// Combinational MMIO window check: says whether a byte address falls inside the
// peripheral window, which slot it selects, and the word-aligned offset in that slot.
module mmio_slot_decode
  import mmio_pkg::*;
#(
  parameter int unsigned NSLAVES   = 4,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int unsigned SLOT_BITS = 3,
  parameter int unsigned SW        = slot_width(NSLAVES)
) (
  input  logic [31:0]          addr_i,
  output logic                 in_mmio_o,
  output logic [SW-1:0]        slot_o,
  output logic [SLOT_BITS-1:0] offset_o
);

  // Upper bound is computed in 33 bits so a window ending at 2^32 cannot wrap
  localparam logic [32:0] WINDOW_SPAN  = 33'(NSLAVES) << SLOT_BITS;
  localparam logic [32:0] WINDOW_LIMIT = {1'b0, MMIO_BASE} + WINDOW_SPAN;

  logic [31:0] rel_s;

  assign rel_s     = addr_i - MMIO_BASE;
  assign in_mmio_o = (addr_i >= MMIO_BASE) && ({1'b0, addr_i} < WINDOW_LIMIT);
  assign slot_o    = SW'(rel_s >> SLOT_BITS);
  // Peripherals are word-addressed, so the byte lane bits are always cleared
  assign offset_o  = rel_s[SLOT_BITS-1:0] & ~(SLOT_BITS'(2'b11));

endmodule

// File: rtl/mmio_bus_bridge.sv
// Bridge between the core data-memory port and NSLAVES peripherals. Non-MMIO
// stores go straight to data memory; MMIO accesses run a select/enable bus
// transaction with ready handshake and timeout, stalling the core meanwhile.
module mmio_bus_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned NSLAVES   = 4,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int unsigned SLOT_BITS = 3,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memwrite,
  input  logic                    memread,
  input  logic [31:0]             addr,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    stall,
  output logic                    bus_err,
  output logic                    we_mem,
  output logic [NSLAVES-1:0]      psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [SLOT_BITS-1:0]    paddr,
  output logic [31:0]             pwdata,
  input  logic [NSLAVES*32-1:0]   prdata,
  input  logic [NSLAVES-1:0]      pready
);

  localparam int unsigned SW = slot_width(NSLAVES);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mmio_state_t          state_q;
  logic [CW-1:0]        cnt_q;
  logic [SW-1:0]        slot_q;
  logic [31:0]          readdata_q;
  logic                 bus_err_q;
  logic [NSLAVES-1:0]   psel_q;
  logic                 penable_q;
  logic                 pwrite_q;
  logic [SLOT_BITS-1:0] paddr_q;
  logic [31:0]          pwdata_q;

  logic                 req_s;
  logic                 in_mmio_s;
  logic [SW-1:0]        dec_slot_s;
  logic [SLOT_BITS-1:0] dec_off_s;
  logic                 sel_ready_s;
  logic [31:0]          sel_rdata_s;

  mmio_slot_decode #(
    .NSLAVES   (NSLAVES),
    .MMIO_BASE (MMIO_BASE),
    .SLOT_BITS (SLOT_BITS),
    .SW        (SW)
  ) u_decode (
    .addr_i    (addr),
    .in_mmio_o (in_mmio_s),
    .slot_o    (dec_slot_s),
    .offset_o  (dec_off_s)
  );

  assign req_s       = memwrite | memread;
  // Only the latched slot's handshake and data matter; other slots are ignored
  assign sel_ready_s = pready[slot_q];
  assign sel_rdata_s = prdata[32 * slot_q +: 32];

  // Data memory sees every store outside the peripheral window, independent of bus state
  assign we_mem = memwrite & ~in_mmio_s;

  // Hold the core from the request cycle itself until the transaction reaches DONE
  assign stall = ((state_q == IDLE) && req_s && in_mmio_s) ||
                 (state_q == SETUP) || (state_q == ACCESS);

  // Transaction sequencer: phase, wait counter and every registered bus output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      readdata_q <= 32'h0000_0000;
      bus_err_q  <= 1'b0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          bus_err_q <= 1'b0;
          if (req_s && in_mmio_s) begin
            state_q   <= SETUP;
            slot_q    <= dec_slot_s;
            paddr_q   <= dec_off_s;
            // A simultaneous load and store is treated as a store
            pwrite_q  <= memwrite;
            pwdata_q  <= writedata;
            psel_q    <= NSLAVES'(1'b1) << dec_slot_s;
            penable_q <= 1'b0;
            cnt_q     <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: begin
          if (sel_ready_s) begin
            state_q   <= DONE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (!pwrite_q) begin
              readdata_q <= sel_rdata_s;
            end else begin
              readdata_q <= readdata_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Peripheral never answered: abort with a poison value and an error pulse
            state_q    <= DONE;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            readdata_q <= TIMEOUT_RDATA;
            bus_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // Always return to IDLE so the still-present request is not relaunched
          state_q   <= IDLE;
          bus_err_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= '0;
          penable_q <= 1'b0;
          bus_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign readdata = readdata_q;
  assign bus_err  = bus_err_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Self-checking bench for mmio_bus_bridge: directed scenarios plus randomized
// transactions, all checked against a transaction-level reference model.
module tb_mmio_bus_bridge;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'hFFFF0000;
  localparam int          SB   = 3;
  localparam int          TO   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              memwrite;
  logic              memread;
  logic [31:0]       addr;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              stall;
  logic              bus_err;
  logic              we_mem;
  logic [NS-1:0]     psel;
  logic              penable;
  logic              pwrite;
  logic [SB-1:0]     paddr;
  logic [31:0]       pwdata;
  logic [NS*32-1:0]  prdata;
  logic [NS-1:0]     pready;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd_model;
  logic [31:0] slave_data [NS];

  always #5 clk = ~clk;

  mmio_bus_bridge #(
    .NSLAVES   (NS),
    .MMIO_BASE (BASE),
    .SLOT_BITS (SB),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .bus_err   (bus_err),
    .we_mem    (we_mem),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  function automatic bit model_in_mmio(input logic [31:0] a);
    longint unsigned lo, hi;
    lo = longint'(BASE);
    hi = lo + longint'(NS * (1 << SB));
    return (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  // One core access from request to completion, checked against the model
  task automatic do_xfer(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input string nm);
    bit            mm;
    bit            fin;
    bit            exp_to;
    int            slot;
    int unsigned   rel;
    int            exp_stall, exp_pen;
    int            stall_n, pen_n, acc;
    logic [NS-1:0] exp_psel;
    logic [SB-1:0] exp_off;
    logic [31:0]   exp_rd;
    mm        = model_in_mmio(a);
    rel       = a - BASE;
    slot      = mm ? int'(rel / (1 << SB)) : 0;
    exp_psel  = mm ? NS'(1 << slot) : '0;
    exp_off   = mm ? SB'((rel % (1 << SB)) / 4 * 4) : '0;
    exp_to    = mm && (waits >= TO);
    exp_stall = !mm ? 0 : (exp_to ? 2 + TO : 3 + waits);
    exp_pen   = !mm ? 0 : (exp_to ? TO : 1 + waits);
    for (int i = 0; i < NS; i++) begin
      slave_data[i] = $urandom;
      prdata[i*32 +: 32] = slave_data[i];
    end
    if (exp_to)               exp_rd = 32'hDEADBEEF;
    else if (mm && !wr && rd) exp_rd = slave_data[slot];
    else                      exp_rd = rd_model;
    stall_n = 0; pen_n = 0; acc = 0; fin = 1'b0;
    @(negedge clk);
    memwrite = wr; memread = rd; addr = a; writedata = wd; pready = '0;
    for (int c = 0; c < TO + 12 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_tests++;
      if (we_mem !== (wr & ~mm)) begin
        n_fail++; $display("FAIL %s we_mem: got %b expected %b", nm, we_mem, wr & ~mm);
      end
      if (stall) begin
        stall_n++;
        n_tests++;
        if (bus_err !== 1'b0) begin
          n_fail++; $display("FAIL %s bus_err_while_stalled: got %b expected 0", nm, bus_err);
        end
      end
      if (psel !== '0) begin
        n_tests++;
        if (psel !== exp_psel) begin
          n_fail++; $display("FAIL %s psel: got %b expected %b", nm, psel, exp_psel);
        end
        n_tests++;
        if (pwrite !== wr || paddr !== exp_off || pwdata !== wd) begin
          n_fail++;
          $display("FAIL %s bus_fields: got pwrite=%b paddr=%0h pwdata=%h expected %b %0h %h",
                   nm, pwrite, paddr, pwdata, wr, exp_off, wd);
        end
      end
      if (penable) pen_n++;
      if (!stall && (mm ? (stall_n > 0) : (c >= 1))) begin
        fin = 1'b1;
        n_tests++;
        if (stall_n !== exp_stall) begin
          n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_n, exp_stall);
        end
        n_tests++;
        if (pen_n !== exp_pen) begin
          n_fail++; $display("FAIL %s penable_cycles: got %0d expected %0d", nm, pen_n, exp_pen);
        end
        n_tests++;
        if (psel !== '0 || penable !== 1'b0) begin
          n_fail++; $display("FAIL %s done_idle_bus: got psel=%b penable=%b expected 0 0", nm, psel, penable);
        end
        n_tests++;
        if (bus_err !== exp_to) begin
          n_fail++; $display("FAIL %s bus_err: got %b expected %b", nm, bus_err, exp_to);
        end
        n_tests++;
        if (readdata !== exp_rd) begin
          n_fail++; $display("FAIL %s readdata: got %h expected %h", nm, readdata, exp_rd);
        end
      end else begin
        pready = NS'($urandom);
        pready[slot] = (penable && psel == exp_psel) ? (acc >= waits) : 1'b0;
        if (penable) acc++;
      end
    end
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL %s completion: got no DONE within budget expected DONE after %0d stalls", nm, exp_stall);
    end
    memwrite = 1'b0; memread = 1'b0; pready = '0;
    rd_model = exp_rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; memwrite = 1'b0; memread = 1'b0; addr = 32'h0;
    writedata = 32'h0; prdata = '0; pready = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (readdata !== 32'h0 || bus_err !== 1'b0 || psel !== '0 || penable !== 1'b0 ||
        pwrite !== 1'b0 || paddr !== '0 || pwdata !== 32'h0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rd=%h err=%b psel=%b pen=%b pw=%b pa=%0h pwd=%h st=%b expected all 0",
               readdata, bus_err, psel, penable, pwrite, paddr, pwdata, stall);
    end
    rd_model = 32'h0;
  endtask

  task automatic test_mem_store();
    do_xfer(1'b1, 1'b0, 32'h0000_0100, 32'h0000_00A5, 0, "mem_store");
  endtask

  task automatic test_read_fast();
    do_xfer(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, 0, "read_fast");
  endtask

  task automatic test_write_wait();
    do_xfer(1'b1, 1'b0, 32'hFFFF_0004, 32'h0000_0055, 5, "write_wait");
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 1'b1, 32'hFFFF_0018, 32'h0, TO + 3, "timeout");
    do_xfer(1'b0, 1'b1, 32'hFFFF_0000, 32'h0, 1, "after_timeout");
  endtask

  task automatic test_boundary();
    do_xfer(1'b1, 1'b0, 32'hFFFE_FFFC, 32'h1234_5678, 0, "below_window");
    do_xfer(1'b1, 1'b0, 32'hFFFF_0020, 32'h8765_4321, 0, "above_window");
    do_xfer(1'b1, 1'b0, 32'hFFFE_FFFF, 32'h0000_0001, 0, "base_minus_1");
    do_xfer(1'b1, 1'b1, 32'hFFFF_0000, 32'hCAFE_0001, 0, "rw_is_write");
    do_xfer(1'b0, 1'b1, 32'hFFFF_001F, 32'h0, 2, "last_byte");
  endtask

  task automatic test_back_to_back();
    time t0, t1;
    do_xfer(1'b0, 1'b1, 32'hFFFF_0010, 32'h0, 0, "b2b_0");
    t0 = $time;
    do_xfer(1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0BB1, 0, "b2b_1");
    do_xfer(1'b0, 1'b1, 32'hFFFF_000C, 32'h0, 0, "b2b_2");
    t1 = $time;
    n_tests++;
    if ((t1 - t0) !== 80) begin
      n_fail++; $display("FAIL b2b_cadence: got %0t expected 80 time units for two accesses", t1 - t0);
    end
  endtask

  task automatic test_reset_during_access();
    bit seen;
    do_xfer(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, 0, "pre_reset_read");
    @(negedge clk);
    memread = 1'b1; addr = 32'hFFFF_0010; pready = '0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      seen = penable;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL rst_access_reach: got penable=%b expected 1", penable);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; memread = 1'b0;
    #1;
    n_tests++;
    if (psel !== '0 || penable !== 1'b0 || readdata !== 32'h0 || bus_err !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_access: got psel=%b pen=%b rd=%h err=%b st=%b expected 0 0 0 0 0",
               psel, penable, readdata, bus_err, stall);
    end
    rd_model = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (bus_err !== 1'b0 || psel !== '0) begin
        n_fail++; $display("FAIL rst_no_err_pulse: got err=%b psel=%b expected 0 0", bus_err, psel);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  kind;
    for (int k = 0; k < 24; k++) begin
      kind = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, NS * (1 << SB) - 1));
      do_xfer(kind[0], kind[1], a, $urandom, int'($urandom_range(0, TO + 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_mem_store();
    test_read_fast();
    test_write_wait();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_reset_during_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_bus_bridge.md
# mmio_bus_bridge

Parametrised memory-mapped I/O bridge between the pipelined MIPS core's data-memory port and NSLAVES peripherals (UART, Ethernet, timers). It decodes each load/store address, forwards non-MMIO stores to data memory, and runs MMIO accesses as a two-phase select/enable bus transaction with a ready handshake. The core is stalled until the peripheral responds or a timeout expires. It replaces the fixed-address, write-only MMIO decoder, adding reads, wait states, timeout/error reporting, and a configurable slot count.

## Interface
- NSLAVES, 4, number of peripheral slots (1..16)
- MMIO_BASE, 32'hFFFF0000, byte address of slot 0; aligned to 2^SLOT_BITS
- SLOT_BITS, 3, log2 of bytes per slot (8-byte slots by default)
- TIMEOUT, 16, maximum ACCESS cycles before abort (>= 2)
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- memwrite  in  1  core store request
- memread  in  1  core load request
- addr  in  32  core byte address
- writedata  in  32  core store data
- readdata  out  32  MMIO load result; valid in the DONE cycle
- stall  out  1  holds the core pipeline
- bus_err  out  1  one-cycle pulse: access timed out
- we_mem  out  1  data-memory write enable
- psel  out  NSLAVES  one-hot slot select
- penable  out  1  access phase
- pwrite  out  1  1 = write, 0 = read
- paddr  out  SLOT_BITS  word-aligned offset within slot; bits [1:0] are always 0
- pwdata  out  32  store data
- prdata  in  NSLAVES*32  slot i's read data is at bits [32i+31:32i]
- pready  in  NSLAVES  per-slot ready

## Operation
- in_mmio is true when MMIO_BASE <= addr < MMIO_BASE + (NSLAVES << SLOT_BITS).
- slot = (addr - MMIO_BASE) >> SLOT_BITS.
- we_mem = memwrite & ~in_mmio. This output is combinational and independent of state.
- A request is memwrite | memread. If both are high, the request is a write.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: on a request with in_mmio, latch slot, offset, pwrite and writedata, then go to SETUP. Non-MMIO requests stay in IDLE.
- SETUP: psel[slot] = 1, penable = 0, for one cycle; then go to ACCESS.
- ACCESS: psel[slot] = 1, penable = 1.
  - If pready[slot] = 1: latch prdata[slot] into readdata (reads only), then go to DONE.
  - Otherwise, increment the wait counter.
  - When the counter equals TIMEOUT-1 and pready is still low: set readdata = TIMEOUT_RDATA, set bus_err, go to DONE.
- DONE: psel = 0, penable = 0, stall = 0, bus_err is high if the access timed out. Go to IDLE.
- stall = (IDLE & request & in_mmio) | SETUP | ACCESS. This is combinational, so the core is held in the request cycle itself.
- readdata holds its value until the next completed MMIO read or a timeout.
- Writes leave readdata unchanged, except on a timeout.
- pready from unselected slots is ignored.

## Timing
- Reset values: state = IDLE, counter = 0, readdata = 0, bus_err = 0, psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0.
- stall is 0 after reset unless an MMIO request is present.
- Minimum MMIO latency: 3 stall cycles (IDLE, SETUP, ACCESS with pready = 1), then DONE with stall low.
- Each cycle of pready low adds one cycle.
- Maximum latency: 2 + TIMEOUT stall cycles.
- The core still presents the same request during DONE. Because DONE always returns to IDLE, no second transaction is launched.
- A new MMIO request is accepted in the IDLE cycle after DONE. Back-to-back accesses therefore cost 4 cycles each.
- Reset asserted in any state returns to IDLE on the next edge.
  - psel and penable drop in that same edge.
  - No bus_err pulse is produced and readdata is cleared.
- Addresses at MMIO_BASE-1 and at MMIO_BASE + (NSLAVES << SLOT_BITS) are non-MMIO: no stall, and we_mem follows memwrite.
- TIMEOUT counting: the first ACCESS cycle is count 0, and the abort decision is taken in the cycle where count = TIMEOUT-1.

## Structure
- Package mmio_pkg contains:
  - mmio_state_t enum (IDLE, SETUP, ACCESS, DONE)
  - TIMEOUT_RDATA = 32'hDEADBEEF
  - default MMIO_BASE
  - slot width helper: $clog2(NSLAVES), minimum 1
- Sub-module mmio_slot_decode: combinational range check. Inputs addr plus parameters; outputs in_mmio, slot index and offset. It is shared with future read-mux logic.
- The counter width is $clog2(TIMEOUT).

## Test plan
- Store writedata = 32'hA5 to addr = 32'h0000_0100 → we_mem = 1, stall = 0, psel never asserts.
- Load from 32'hFFFF0008 with pready[1] high in the first ACCESS cycle → psel = 4'b0010, paddr = 0, stall high for 3 cycles, readdata = prdata[1] in DONE.
- Store 32'h55 to 32'hFFFF0004 while slot 0 holds pready low for 5 cycles → penable high for 6 cycles, pwdata = 32'h55, pwrite = 1, we_mem = 0, stall high for 8 cycles.
- Load from slot 3 with pready never asserted → bus_err pulses after 2 + TIMEOUT stall cycles, readdata = 32'hDEADBEEF, next request accepted.
- Boundary addresses 32'hFFFEFFFC and 32'hFFFF0020 with NSLAVES = 4 → no stall; memwrite and memread both high on 32'hFFFF0000 → pwrite = 1.
- Reset asserted during ACCESS → next cycle IDLE, psel = 0, penable = 0, readdata = 0, no bus_err pulse.
